addr_sram_fifo_ctrl: RTL and testbench
======================================

# addr_sram_fifo_ctrl

Ready/valid FIFO controller that owns the 1W1R, registered-read-address SRAM macro of the address queue (8 × 17 bits in the 1c8w16t configuration). It sequences write and read ports, hides the one-cycle read latency behind a 2-entry output skid buffer, and sits between the address producer (upstream, enq side) and the consuming stage (downstream, deq side).

## Interface
- DATA_W, 17, entry width; must match the SRAM data width
- ADDR_W, 3, SRAM address width; RAM depth DEPTH = 2**ADDR_W
- clock  in  1  single clock; also drives both SRAM clocks
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all contents
- enq_valid  in  1  producer has data
- enq_ready  out  1  controller accepts data
- enq_data  in  DATA_W  payload
- deq_valid  out  1  head entry available
- deq_ready  in  1  consumer accepts head
- deq_data  out  DATA_W  head payload
- count  out  ADDR_W+1  total entries held (RAM + in-flight + skid)
- W0_addr / W0_en / W0_data  out  ADDR_W / 1 / DATA_W  SRAM write port
- R0_addr / R0_en  out  ADDR_W / 1  SRAM read request
- R0_data  in  DATA_W  SRAM read data, valid the cycle after an R0_en cycle

## Operation
- State: wr_ptr, rd_ptr (ADDR_W, wrap modulo DEPTH), ram_cnt (0..DEPTH), inflight (1 bit), skid buffer occ (0..2) with head index.
- enq_fire = enq_valid & enq_ready; enq_ready = (ram_cnt < DEPTH) & ~flush. No "full-but-reading" pass-through.
- Write: W0_en = enq_fire, W0_addr = wr_ptr, W0_data = enq_data; wr_ptr++.
- Read issue: R0_en = (ram_cnt > 0) & (occ + inflight − deq_fire < 2) & ~flush; R0_addr = rd_ptr; rd_ptr++, inflight set next cycle.
- Return: when inflight, R0_data is written into the skid buffer tail at the clock edge.
- deq_valid = occ > 0; deq_data = skid[head]; deq_fire pops head.
- ram_cnt next = ram_cnt + enq_fire − R0_en. count = ram_cnt + inflight + occ.
- Write/read address collision cannot occur: read requires ram_cnt > 0, write requires ram_cnt < DEPTH, so rd_ptr ≠ wr_ptr whenever both are active.
- flush: next cycle all pointers, counts, occ and inflight are 0; a read returning during the flush cycle is discarded; enq/deq suppressed that cycle (deq_valid still shows pre-flush state, but deq_fire is ignored).
- Capacity DEPTH + 2 entries counted; enq only gated by RAM occupancy.

## Timing
- Reset (reset_n low): all state 0; outputs deq_valid=0, enq_ready=0, count=0, W0_en=0, R0_en=0, addresses 0, deq_data 0. enq_ready rises the first cycle after release.
- Latency, empty FIFO, no bypass: enq_fire cycle 0 → R0_en cycle 1 → R0_data cycle 2 → deq_valid cycle 3.
- Steady state with deq_ready=1: one entry per cycle in and out, no bubbles.
- deq_ready=0 with stream: at most 2 reads issued past the stall; R0_en drops once occ+inflight = 2.
- Simultaneous enq_fire and R0_en at ram_cnt = DEPTH−1 or 1: both take effect, ram_cnt unchanged.
- Pointer wrap DEPTH−1 → 0 with no gap.

## Configuration
- ADDR_FIFO_BYPASS_EN defined: when ram_cnt=0, inflight=0 and occ − deq_fire < 2, enq_fire writes enq_data directly into the skid buffer (W0_en=0, wr_ptr unchanged); empty-to-deq_valid latency 1 cycle. Ordering preserved since RAM and pipe are empty.
- Undefined: all entries pass through the SRAM; latency 3 cycles as above.

## Test plan
- Reset then single enq 0x1ABCD → deq_valid at cycle 3 (1 with bypass), deq_data 0x1ABCD, count 1→0 after deq.
- Fill 10 entries 0..9 with deq_ready=0 → enq_ready=0 after 10th, count=10, RAM write addresses 0..7, R0_en exactly twice.
- Continuous enq/deq of 100 incrementing values, deq_ready=1 → in-order output, 1/cycle after fill, pointers wrap cleanly.
- Random deq_ready toggling (50%) with random enq → scoreboard match, occ never > 2, no RAM collision.
- flush while inflight=1 and count=6 → next cycle count=0, deq_valid=0; stale R0_data never appears on deq.
- reset_n asserted mid-stream → outputs zero immediately (async), first enq after release returns intact.

Source files
------------

// File: rtl/addr_sram_fifo_ctrl_if.sv
// Ready/valid handshake bundle between the address producer, the FIFO controller and the consumer.
interface addr_sram_fifo_ctrl_if #(
  parameter int unsigned DATA_W = 17,
  parameter int unsigned ADDR_W = 3
);
  logic              enq_valid;
  logic              enq_ready;
  logic [DATA_W-1:0] enq_data;
  logic              deq_valid;
  logic              deq_ready;
  logic [DATA_W-1:0] deq_data;
  logic [ADDR_W:0]   count;

  modport master (
    output enq_valid, enq_data, deq_ready,
    input  enq_ready, deq_valid, deq_data, count
  );

  modport slave (
    input  enq_valid, enq_data, deq_ready,
    output enq_ready, deq_valid, deq_data, count
  );
endinterface

// File: rtl/addr_sram_fifo_ctrl.sv
// FIFO controller around a 1W1R registered-read SRAM, hiding read latency with a 2-entry skid.
// Optional macro ADDR_FIFO_BYPASS_EN lets an enqueue into an empty FIFO skip the SRAM.
module addr_sram_fifo_ctrl #(
  parameter int unsigned DATA_W = 17,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  addr_sram_fifo_ctrl_if.slave  fifo,
  output logic [ADDR_W-1:0]     W0_addr,
  output logic                  W0_en,
  output logic [DATA_W-1:0]     W0_data,
  output logic [ADDR_W-1:0]     R0_addr,
  output logic                  R0_en,
  input  logic [DATA_W-1:0]     R0_data
);

  logic              ready_q;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        occ_q, occ_d;
  logic              head_q, head_d;
  logic [DATA_W-1:0] skid_q [2];

  logic              enq_ready, enq_fire, deq_valid, deq_fire;
  logic              bypass, to_ram, rd_en, push;
  logic [DATA_W-1:0] push_data;
  logic [2:0]        pipe_occ;

  always_comb begin
    // ram_cnt never exceeds DEPTH, so its MSB alone flags a full RAM
    enq_ready = ready_q & ~ram_cnt_q[ADDR_W] & ~flush;
    enq_fire  = fifo.enq_valid & enq_ready;
    deq_valid = (occ_q != 2'd0);
    deq_fire  = deq_valid & fifo.deq_ready & ~flush;
    pipe_occ  = {1'b0, occ_q} + {2'b00, inflight_q};
    rd_en     = (ram_cnt_q != '0) & ~flush &
                ((pipe_occ < 3'd2) | ((pipe_occ == 3'd2) & deq_fire));
`ifdef ADDR_FIFO_BYPASS_EN
    bypass    = (ram_cnt_q == '0) & ~inflight_q & ((occ_q < 2'd2) | deq_fire);
`else
    bypass    = 1'b0;
`endif
    to_ram    = enq_fire & ~bypass;
    // Bypass requires an empty read pipe, so the two push sources never coincide
    push      = (inflight_q & ~flush) | (enq_fire & bypass);
    push_data = inflight_q ? R0_data : fifo.enq_data;

    wr_ptr_d   = to_ram ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d   = rd_en ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    ram_cnt_d  = ram_cnt_q + (ADDR_W+1)'(to_ram) - (ADDR_W+1)'(rd_en);
    inflight_d = rd_en;
    occ_d      = occ_q + 2'(push) - 2'(deq_fire);
    head_d     = head_q ^ deq_fire;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      ram_cnt_d  = '0;
      inflight_d = 1'b0;
      occ_d      = 2'd0;
      head_d     = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      head_q     <= 1'b0;
      skid_q[0]  <= '0;
      skid_q[1]  <= '0;
    end else begin
      ready_q    <= 1'b1;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      // Tail slot is head+occ; occ is at most 1 whenever a push happens
      if (push) skid_q[head_q ^ occ_q[0]] <= push_data;
    end
  end

  assign fifo.enq_ready = enq_ready;
  assign fifo.deq_valid = deq_valid;
  assign fifo.deq_data  = skid_q[head_q];
  assign fifo.count     = ram_cnt_q + (ADDR_W+1)'(inflight_q) + (ADDR_W+1)'(occ_q);

  assign W0_en   = to_ram;
  assign W0_addr = wr_ptr_q;
  assign W0_data = fifo.enq_data;
  assign R0_en   = rd_en;
  assign R0_addr = rd_ptr_q;

endmodule

// File: tb/tb_addr_sram_fifo_ctrl.sv
// Directed and scoreboarded bench for addr_sram_fifo_ctrl with a behavioural 8x17 SRAM.
module tb_addr_sram_fifo_ctrl;
  localparam int DW = 17;
  localparam int AW = 3;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  always #5 clock = ~clock;

  addr_sram_fifo_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  logic [AW-1:0] W0_addr, R0_addr;
  logic          W0_en, R0_en;
  logic [DW-1:0] W0_data, R0_data;
  logic [DW-1:0] mem [8];

  always @(posedge clock) begin
    if (W0_en) mem[W0_addr] <= W0_data;
    if (R0_en) R0_data <= mem[R0_addr];
  end

  addr_sram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .fifo    (bus.slave),
    .W0_addr (W0_addr),
    .W0_en   (W0_en),
    .W0_data (W0_data),
    .R0_addr (R0_addr),
    .R0_en   (R0_en),
    .R0_data (R0_data)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  logic [DW-1:0] sb [$];
  bit mon = 1'b0;
  int cyc = 0, n_deq = 0, n_enq = 0, first_deq = -1, last_deq = -1;

  task automatic tick();
    logic [DW-1:0] exp;
    @(negedge clock);
    if (mon) begin
      chk("count_vs_model", 32'(bus.count), 32'(sb.size()));
      if (W0_en && R0_en) chk("ram_collision", 32'(W0_addr != R0_addr), 32'd1);
      if (flush) sb.delete();
      else begin
        if (bus.deq_valid && bus.deq_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL deq_unexpected: got 0x%0h expected no data", bus.deq_data);
          end else begin
            exp = sb.pop_front();
            chk("deq_data", 32'(bus.deq_data), 32'(exp));
          end
          n_deq++;
          last_deq = cyc;
          if (first_deq < 0) first_deq = cyc;
        end
        if (bus.enq_valid && bus.enq_ready) begin
          sb.push_back(bus.enq_data);
          n_enq++;
        end
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic drain(input string name);
    bus.enq_valid = 1'b0;
    bus.deq_ready = 1'b1;
    for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sb.delete();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic          ev;
    logic [DW-1:0] ed;
    logic          dr;
    logic          er;
    logic          dv;
    logic [DW-1:0] dd;
    logic [3:0]    cnt;
    logic          we;
    logic          re;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int n_r0;
    // ev  ed        dr   er   dv   dd        cnt  we   re
    vecs[0]  = '{1'b1, 17'h1ABCD, 1'b1, 1'b1, 1'b0, 17'h0,     4'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 17'h0,     1'b1, 1'b1, 1'b0, 17'h0,     4'd1, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 17'h0,     1'b1, 1'b1, 1'b0, 17'h0,     4'd1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 17'h0,     1'b1, 1'b1, 1'b1, 17'h1ABCD, 4'd1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 17'h0,     1'b1, 1'b1, 1'b0, 17'h0,     4'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 17'h00011, 1'b1, 1'b1, 1'b0, 17'h0,     4'd0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 17'h00022, 1'b1, 1'b1, 1'b0, 17'h0,     4'd1, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 17'h0,     1'b1, 1'b1, 1'b0, 17'h0,     4'd2, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 17'h0,     1'b1, 1'b1, 1'b1, 17'h00011, 4'd2, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 17'h0,     1'b1, 1'b1, 1'b1, 17'h00022, 4'd1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 17'h0,     1'b1, 1'b1, 1'b0, 17'h0,     4'd0, 1'b0, 1'b0};

    bus.enq_valid = 1'b1;
    bus.enq_data  = 17'h0;
    bus.deq_ready = 1'b1;

    // Reset state, with a producer already asserting valid
    #12;
    chk("rst_enq_ready", 32'(bus.enq_ready), 32'd0);
    chk("rst_deq_valid", 32'(bus.deq_valid), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_w0_en", 32'(W0_en), 32'd0);
    chk("rst_r0_en", 32'(R0_en), 32'd0);
    chk("rst_deq_data", 32'(bus.deq_data), 32'd0);
    chk("rst_addrs", 32'({W0_addr, R0_addr}), 32'd0);
    bus.enq_valid = 1'b0;
    do_reset();

    // Table: single enq latency, then back-to-back pair
    for (int i = 0; i < 11; i++) begin
      bus.enq_valid = vecs[i].ev;
      bus.enq_data  = vecs[i].ed;
      bus.deq_ready = vecs[i].dr;
      @(negedge clock);
      chk($sformatf("v%0d_enq_ready", i), 32'(bus.enq_ready), 32'(vecs[i].er));
      chk($sformatf("v%0d_deq_valid", i), 32'(bus.deq_valid), 32'(vecs[i].dv));
      if (vecs[i].dv) chk($sformatf("v%0d_deq_data", i), 32'(bus.deq_data), 32'(vecs[i].dd));
      chk($sformatf("v%0d_count", i), 32'(bus.count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_w0_en", i), 32'(W0_en), 32'(vecs[i].we));
      chk($sformatf("v%0d_r0_en", i), 32'(R0_en), 32'(vecs[i].re));
      @(posedge clock);
      #1;
    end

    // Fill 10 with consumer stalled
    do_reset();
    bus.deq_ready = 1'b0;
    n_r0 = 0;
    for (int i = 0; i < 10; i++) begin
      bus.enq_valid = 1'b1;
      bus.enq_data  = 17'(i);
      @(negedge clock);
      chk($sformatf("fill%0d_enq_ready", i), 32'(bus.enq_ready), 32'd1);
      chk($sformatf("fill%0d_w0_addr", i), 32'(W0_addr), 32'(i % 8));
      n_r0 += int'(R0_en);
      if (bus.enq_ready) sb.push_back(bus.enq_data);
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    chk("full_enq_ready", 32'(bus.enq_ready), 32'd0);
    chk("full_count", 32'(bus.count), 32'd10);
    chk("full_w0_en", 32'(W0_en), 32'd0);
    n_r0 += int'(R0_en);
    chk("full_r0_issued", 32'(n_r0), 32'd2);
    @(posedge clock);
    #1;
    mon = 1'b1;
    drain("fill_drain");

    // Flush while a read is in flight and 6 entries are held
    bus.deq_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.enq_valid = 1'b1;
      bus.enq_data  = 17'(32'h100 + i);
      tick();
    end
    bus.enq_data  = 17'h106;
    bus.deq_ready = 1'b1;
    tick();
    mon = 1'b0;
    flush = 1'b1;
    @(negedge clock);
    chk("flush_pre_count", 32'(bus.count), 32'd6);
    chk("flush_enq_ready", 32'(bus.enq_ready), 32'd0);
    chk("flush_w0_en", 32'(W0_en), 32'd0);
    chk("flush_r0_en", 32'(R0_en), 32'd0);
    chk("flush_deq_valid_pre", 32'(bus.deq_valid), 32'd1);
    @(posedge clock);
    #1;
    flush = 1'b0;
    sb.delete();
    bus.enq_valid = 1'b0;
    @(negedge clock);
    chk("flush_post_count", 32'(bus.count), 32'd0);
    chk("flush_post_deq_valid", 32'(bus.deq_valid), 32'd0);
    @(posedge clock);
    #1;
    mon = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.enq_valid = 1'b1;
    bus.enq_data  = 17'h0BEEF;
    tick();
    drain("flush_recover");

    // Continuous stream of 100 values from empty
    do_reset();
    mon = 1'b1;
    cyc = 0; n_deq = 0; n_enq = 0; first_deq = -1; last_deq = -1;
    bus.deq_ready = 1'b1;
    for (int k = 0; k < 150 && n_deq < 100; k++) begin
      bus.enq_valid = (n_enq < 100);
      bus.enq_data  = 17'(n_enq + 32'h500);
      tick();
    end
    chk("stream_deq_total", 32'(n_deq), 32'd100);
    chk("stream_first_deq_cycle", 32'(first_deq), 32'd3);
    chk("stream_no_bubbles", 32'(last_deq - first_deq), 32'd99);

    // Random handshakes
    for (int k = 0; k < 300; k++) begin
      bus.enq_valid = 1'($urandom_range(1));
      bus.enq_data  = 17'($urandom);
      bus.deq_ready = 1'($urandom_range(1));
      tick();
    end
    drain("random_drain");

    // Asynchronous reset mid-stream
    bus.deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.enq_valid = 1'b1;
      bus.enq_data  = 17'(32'h700 + i);
      tick();
    end
    mon = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_enq_ready", 32'(bus.enq_ready), 32'd0);
    chk("arst_deq_valid", 32'(bus.deq_valid), 32'd0);
    chk("arst_count", 32'(bus.count), 32'd0);
    chk("arst_w0_en", 32'(W0_en), 32'd0);
    chk("arst_r0_en", 32'(R0_en), 32'd0);
    chk("arst_deq_data", 32'(bus.deq_data), 32'd0);
    sb.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    mon = 1'b1;
    bus.enq_valid = 1'b1;
    bus.enq_data  = 17'h15A5A;
    tick();
    drain("arst_recover");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
